// File: rtl/pc_link_pkg.sv
// Shared types for the PC UART link multiplexer: FSM state encoding and
// the RX steering selects.
package pc_link_pkg;

   typedef enum logic [1:0] {
      S_MSP   = 2'b00,
      S_ARM   = 2'b01,
      S_PT    = 2'b10,
      S_DRAIN = 2'b11
   } state_t;

   typedef logic [1:0] rx_sel_t;

   localparam rx_sel_t RX_SEL_NONE = 2'd0;
   localparam rx_sel_t RX_SEL_MSP  = 2'd1;
   localparam rx_sel_t RX_SEL_ESC  = 2'd2;

endpackage

// File: rtl/pc_tx_skid.sv
// One-entry holding register between the granted TX source and the PC UART.
// Data is only reloaded on an accepted transfer, so it stays put while stalled.
module pc_tx_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_data,
   input  logic         i_valid,
   output logic         o_ready,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   input  logic         i_ready
);

   logic [W-1:0] r_data;
   logic         r_valid;

   assign o_ready = !r_valid || i_ready;
   assign o_data  = r_data;
   assign o_valid = r_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_valid && o_ready) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_link_mux.sv
// Shares one PC UART between the MSP responder and an ESC passthrough bridge,
// with an idle timeout that drops passthrough back to MSP mode.
module pc_link_mux
   import pc_link_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 72_000_000,
   parameter int TIMEOUT_MS  = 5000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] pc_rx_data,
   input  logic       pc_rx_valid,
   output logic [7:0] pc_tx_data,
   output logic       pc_tx_valid,
   input  logic       pc_tx_ready,
   output logic [7:0] msp_rx_data,
   output logic       msp_rx_valid,
   input  logic [7:0] msp_tx_data,
   input  logic       msp_tx_valid,
   output logic       msp_tx_ready,
   input  logic       msp_active,
   input  logic       passthru_req,
   output logic [7:0] esc_rx_data,
   output logic       esc_rx_valid,
   input  logic [7:0] esc_tx_data,
   input  logic       esc_tx_valid,
   output logic       esc_tx_ready,
   input  logic       esc_exit,
   output logic       passthru_active,
   output logic       timeout_evt
);

   localparam int             TO_CYCLES = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
   localparam int             CW        = $clog2(TO_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_RLD   = CW'(TO_CYCLES - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_run;
   logic [7:0]    r_msp_rx_data, r_esc_rx_data;
   logic          r_msp_rx_valid, r_esc_rx_valid;
   logic          r_pt_active, r_timeout;

   rx_sel_t       w_rx_sel;
   logic          w_grant_msp, w_grant_esc, w_skid_rdy;
   logic          w_tx_valid, w_reload, w_tc;
   logic [7:0]    w_tx_data;

   always_comb begin
      w_rx_sel = RX_SEL_NONE;
      case (r_state)
         S_MSP:   w_rx_sel = RX_SEL_MSP;
         S_PT:    w_rx_sel = RX_SEL_ESC;
         default: w_rx_sel = RX_SEL_NONE;
      endcase
   end

   // r_run keeps both readies low until the first edge after reset release.
   assign w_grant_msp = r_run && ((r_state == S_MSP) || (r_state == S_ARM));
   assign w_grant_esc = r_run && (r_state == S_PT);
   assign w_tx_valid  = (w_grant_msp && msp_tx_valid) || (w_grant_esc && esc_tx_valid);
   assign w_tx_data   = w_grant_esc ? esc_tx_data : msp_tx_data;

   assign msp_tx_ready = w_grant_msp && w_skid_rdy;
   assign esc_tx_ready = w_grant_esc && w_skid_rdy;

   assign w_reload = pc_rx_valid || (esc_tx_valid && esc_tx_ready);
   assign w_tc     = (r_cnt == '0) && !w_reload;

   pc_tx_skid #(.W(8)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (w_tx_data),
      .i_valid (w_tx_valid),
      .o_ready (w_skid_rdy),
      .o_data  (pc_tx_data),
      .o_valid (pc_tx_valid),
      .i_ready (pc_tx_ready)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_MSP;
         r_cnt          <= CNT_RLD;
         r_run          <= 1'b0;
         r_msp_rx_data  <= '0;
         r_msp_rx_valid <= 1'b0;
         r_esc_rx_data  <= '0;
         r_esc_rx_valid <= 1'b0;
         r_pt_active    <= 1'b0;
         r_timeout      <= 1'b0;
      end else begin
         r_run          <= 1'b1;
         r_timeout      <= 1'b0;
         r_msp_rx_valid <= pc_rx_valid && (w_rx_sel == RX_SEL_MSP);
         r_esc_rx_valid <= pc_rx_valid && (w_rx_sel == RX_SEL_ESC);
         if (pc_rx_valid && (w_rx_sel == RX_SEL_MSP)) r_msp_rx_data <= pc_rx_data;
         if (pc_rx_valid && (w_rx_sel == RX_SEL_ESC)) r_esc_rx_data <= pc_rx_data;

         case (r_state)
            S_MSP: if (passthru_req) r_state <= S_ARM;
            S_ARM: if (!msp_active && !msp_tx_valid && !pc_tx_valid) begin
               r_state     <= S_PT;
               r_pt_active <= 1'b1;
               r_cnt       <= CNT_RLD;
            end
            S_PT: begin
               // Explicit exit wins over a coincident timeout: no event pulse.
               if (esc_exit || w_tc) begin
                  r_state   <= S_DRAIN;
                  r_timeout <= !esc_exit;
                  r_cnt     <= CNT_RLD;
               end else if (w_reload) begin
                  r_cnt <= CNT_RLD;
               end else if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_DRAIN: if (!pc_tx_valid) begin
               r_state     <= S_MSP;
               r_pt_active <= 1'b0;
            end
            default: r_state <= S_MSP;
         endcase
      end
   end

   assign msp_rx_data     = r_msp_rx_data;
   assign msp_rx_valid    = r_msp_rx_valid;
   assign esc_rx_data     = r_esc_rx_data;
   assign esc_rx_valid    = r_esc_rx_valid;
   assign passthru_active = r_pt_active;
   assign timeout_evt     = r_timeout;

endmodule

// File: tb/tb_pc_link_mux.sv
// Bench for pc_link_mux: directed scenarios plus randomized traffic, all
// checked every cycle against a mode/queue-level model of the link.
module tb_pc_link_mux;

   localparam int TO = 10;
   localparam int M_MSP = 0, M_ARM = 1, M_PT = 2, M_DRAIN = 3;

   logic       clk = 0, rst_n = 0;
   logic [7:0] pc_rx_data = 0, msp_tx_data = 0, esc_tx_data = 0;
   logic       pc_rx_valid = 0, pc_tx_ready = 1, msp_tx_valid = 0, msp_active = 0;
   logic       passthru_req = 0, esc_tx_valid = 0, esc_exit = 0;
   logic [7:0] pc_tx_data, msp_rx_data, esc_rx_data;
   logic       pc_tx_valid, msp_rx_valid, msp_tx_ready, esc_rx_valid, esc_tx_ready;
   logic       passthru_active, timeout_evt;

   int n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   pc_link_mux #(.CLK_FREQ_HZ(1000), .TIMEOUT_MS(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .pc_rx_data(pc_rx_data), .pc_rx_valid(pc_rx_valid),
      .pc_tx_data(pc_tx_data), .pc_tx_valid(pc_tx_valid), .pc_tx_ready(pc_tx_ready),
      .msp_rx_data(msp_rx_data), .msp_rx_valid(msp_rx_valid),
      .msp_tx_data(msp_tx_data), .msp_tx_valid(msp_tx_valid), .msp_tx_ready(msp_tx_ready),
      .msp_active(msp_active), .passthru_req(passthru_req),
      .esc_rx_data(esc_rx_data), .esc_rx_valid(esc_rx_valid),
      .esc_tx_data(esc_tx_data), .esc_tx_valid(esc_tx_valid), .esc_tx_ready(esc_tx_ready),
      .esc_exit(esc_exit), .passthru_active(passthru_active), .timeout_evt(timeout_evt)
   );

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: link mode, quiet-cycle count since last PT activity, TX holding slot.
   int         m_mode = M_MSP, m_quiet = 0;
   bit         m_run = 0, m_txv = 0, m_mrv = 0, m_erv = 0, m_to = 0;
   logic [7:0] m_txd = 0, m_mrd = 0, m_erd = 0;

   always @(posedge clk or negedge rst_n) begin
      bit gm, ge, can, macc, eacc;
      int nm;
      if (!rst_n) begin
         m_mode = M_MSP; m_quiet = 0; m_run = 0; m_txv = 0; m_txd = 0;
         m_mrv = 0; m_erv = 0; m_to = 0;
      end else begin
         gm   = m_run && (m_mode == M_MSP || m_mode == M_ARM);
         ge   = m_run && (m_mode == M_PT);
         can  = !m_txv || pc_tx_ready;
         macc = gm && can && msp_tx_valid;
         eacc = ge && can && esc_tx_valid;
         m_mrv = (m_mode == M_MSP) && pc_rx_valid;
         m_erv = (m_mode == M_PT) && pc_rx_valid;
         if (m_mrv) m_mrd = pc_rx_data;
         if (m_erv) m_erd = pc_rx_data;
         m_to = 0;
         nm = m_mode;
         case (m_mode)
            M_MSP:   if (passthru_req) nm = M_ARM;
            M_ARM:   if (!msp_active && !msp_tx_valid && !m_txv) begin nm = M_PT; m_quiet = 0; end
            M_PT: begin
               m_quiet = (pc_rx_valid || eacc) ? 0 : m_quiet + 1;
               if (esc_exit) nm = M_DRAIN;
               else if (m_quiet >= TO) begin nm = M_DRAIN; m_to = 1; end
            end
            default: if (!m_txv) nm = M_MSP;
         endcase
         if (macc)             begin m_txv = 1; m_txd = msp_tx_data; end
         else if (eacc)        begin m_txv = 1; m_txd = esc_tx_data; end
         else if (pc_tx_ready) m_txv = 0;
         m_mode = nm;
         m_run  = 1;
      end
   end

   always @(negedge clk) begin
      bit can;
      can = !m_txv || pc_tx_ready;
      cmp("msp_rx_valid", msp_rx_valid, m_mrv);
      cmp("esc_rx_valid", esc_rx_valid, m_erv);
      if (m_mrv) cmp("msp_rx_data", msp_rx_data, m_mrd);
      if (m_erv) cmp("esc_rx_data", esc_rx_data, m_erd);
      cmp("pc_tx_valid", pc_tx_valid, m_txv);
      if (m_txv) cmp("pc_tx_data", pc_tx_data, m_txd);
      cmp("msp_tx_ready", msp_tx_ready, m_run && (m_mode == M_MSP || m_mode == M_ARM) && can);
      cmp("esc_tx_ready", esc_tx_ready, m_run && (m_mode == M_PT) && can);
      cmp("passthru_active", passthru_active, (m_mode == M_PT || m_mode == M_DRAIN));
      cmp("timeout_evt", timeout_evt, m_to);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic enter_pt();
      passthru_req = 1; tick(); passthru_req = 0; tick();
      cmp("enter_pt_active", passthru_active, 1);
   endtask

   initial begin
      logic [7:0] bytes [3];
      int n, act_pct;
      bytes[0] = 8'h24; bytes[1] = 8'h4D; bytes[2] = 8'h3C;

      repeat (3) tick();
      cmp("rst_msp_tx_ready", msp_tx_ready, 0);
      cmp("rst_esc_tx_ready", esc_tx_ready, 0);
      cmp("rst_pc_tx_valid", pc_tx_valid, 0);
      cmp("rst_passthru", passthru_active, 0);
      rst_n = 1; tick();

      for (int i = 0; i < 3; i++) begin
         pc_rx_data = bytes[i]; pc_rx_valid = 1; tick();
         cmp("msp_rx_fwd_valid", msp_rx_valid, 1);
         cmp("msp_rx_fwd_data", msp_rx_data, bytes[i]);
         cmp("msp_rx_esc_quiet", esc_rx_valid, 0);
      end
      pc_rx_valid = 0;

      pc_tx_ready = 0; msp_tx_data = 8'h24; msp_tx_valid = 1; tick();
      msp_tx_data = 8'h99;
      for (int i = 0; i < 5; i++) begin
         cmp("hold_data", pc_tx_data, 8'h24);
         cmp("hold_msp_ready", msp_tx_ready, 0);
         tick();
      end
      msp_tx_valid = 0; pc_tx_ready = 1; tick();
      cmp("hold_release", pc_tx_valid, 0);

      msp_active = 1; passthru_req = 1; tick(); passthru_req = 0;
      pc_rx_data = 8'h55; pc_rx_valid = 1; tick(); pc_rx_valid = 0;
      cmp("arm_drop_msp", msp_rx_valid, 0);
      cmp("arm_drop_esc", esc_rx_valid, 0);
      tick();
      cmp("arm_wait", passthru_active, 0);
      msp_active = 0; tick();
      cmp("arm_to_pt", passthru_active, 1);

      pc_rx_data = 8'h2F; pc_rx_valid = 1; tick(); pc_rx_valid = 0;
      cmp("pt_rx_valid", esc_rx_valid, 1);
      cmp("pt_rx_data", esc_rx_data, 8'h2F);
      esc_tx_data = 8'h30; esc_tx_valid = 1; msp_tx_data = 8'h77; msp_tx_valid = 1; #1;
      cmp("pt_msp_ready", msp_tx_ready, 0);
      cmp("pt_esc_ready", esc_tx_ready, 1);
      tick(); esc_tx_valid = 0; msp_tx_valid = 0;
      cmp("pt_tx_data", pc_tx_data, 8'h30);

      n = 0;
      while (!timeout_evt && n < 30) begin tick(); n++; end
      cmp("timeout_cycles", n, 10);
      cmp("timeout_drain", passthru_active, 1);
      tick();
      cmp("timeout_back_msp", passthru_active, 0);

      enter_pt();
      repeat (9) tick();
      cmp("tc_no_early", timeout_evt, 0);
      pc_rx_data = 8'hA5; pc_rx_valid = 1; tick(); pc_rx_valid = 0;
      cmp("tc_rx_delivered", esc_rx_valid, 1);
      cmp("tc_rx_no_evt", timeout_evt, 0);
      cmp("tc_rx_stay", passthru_active, 1);

      repeat (9) tick();
      esc_exit = 1; tick(); esc_exit = 0;
      cmp("both_no_evt", timeout_evt, 0);
      cmp("both_drain", passthru_active, 1);
      tick();
      cmp("both_msp", passthru_active, 0);

      enter_pt();
      pc_tx_ready = 0; esc_tx_data = 8'h31; esc_tx_valid = 1; tick(); esc_tx_valid = 0;
      esc_exit = 1; tick(); esc_exit = 0;
      for (int i = 0; i < 3; i++) begin
         cmp("drain_hold", passthru_active, 1);
         cmp("drain_data", pc_tx_data, 8'h31);
         cmp("drain_esc_ready", esc_tx_ready, 0);
         tick();
      end
      pc_tx_ready = 1; tick(); tick();
      cmp("drain_exit", passthru_active, 0);
      cmp("drain_empty", pc_tx_valid, 0);

      enter_pt();
      pc_tx_ready = 0; esc_tx_data = 8'h42; esc_tx_valid = 1; tick(); esc_tx_valid = 0;
      cmp("mid_rst_pending", pc_tx_valid, 1);
      rst_n = 0; #1;
      cmp("mid_rst_txv", pc_tx_valid, 0);
      cmp("mid_rst_pt", passthru_active, 0);
      tick(); rst_n = 1; tick();
      cmp("post_rst_txv", pc_tx_valid, 0);
      cmp("post_rst_pt", passthru_active, 0);
      pc_tx_ready = 1;

      act_pct = 40;
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) begin
            case ($urandom_range(0, 2))
               0:       act_pct = 50;
               1:       act_pct = 10;
               default: act_pct = 1;
            endcase
         end
         pc_rx_valid  = ($urandom_range(0, 99) < act_pct);
         pc_rx_data   = 8'($urandom);
         msp_tx_valid = ($urandom_range(0, 99) < act_pct);
         msp_tx_data  = 8'($urandom);
         esc_tx_valid = ($urandom_range(0, 99) < act_pct);
         esc_tx_data  = 8'($urandom);
         msp_active   = ($urandom_range(0, 99) < 30);
         passthru_req = ($urandom_range(0, 99) < 5);
         esc_exit     = ($urandom_range(0, 99) < 2);
         pc_tx_ready  = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 1499) == 0) begin
            rst_n = 0; tick(); rst_n = 1;
         end
         tick();
      end

      pc_rx_valid = 0; msp_tx_valid = 0; esc_tx_valid = 0;
      passthru_req = 0; esc_exit = 0; pc_tx_ready = 1;
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
